// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer sequencer: state encoding,
// default geometry and the watchdog slack.
package fc_pkg;

    localparam int N_IN_DEF   = 30;
    localparam int N_OUT_DEF  = 10;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 9;

    // Extra RUN cycles granted past the last weight fetch before the
    // datapath is declared hung.
    localparam int WD_SLACK   = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        ARGMAX,
        DONE,
        ERR
    } fc_state_e;

endpackage

// File: rtl/fc_argmax.sv
// Argmax scanner: latches the datapath result vector and walks it one entry
// per cycle, keeping the first (lowest-index) maximum. best_idx is 1-based
// and valid in the cycle that last is high. Only built with FC_ARGMAX_EN.
module fc_argmax
    import fc_pkg::*;
#(
    parameter int N_OUT  = N_OUT_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          load,
    input  logic [N_OUT-1:0][DATA_W-1:0]  result,
    input  logic                          scan,
    output logic                          last,
    output logic [3:0]                    best_idx
);

    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(N_OUT - 1);

    logic [N_OUT-1:0][DATA_W-1:0] res_q;
    logic [IW-1:0]                idx_q;
    logic signed [DATA_W-1:0]     best_q;
    logic [3:0]                   best1_q;
    logic signed [DATA_W-1:0]     cur;
    logic                         take;

    // Strictly-greater compare so ties keep the earlier class.
    always_comb begin
        cur      = res_q[idx_q];
        take     = (idx_q == '0) || (cur > best_q);
        last     = scan && (idx_q == LAST_I);
        best_idx = take ? (4'(idx_q) + 4'd1) : best1_q;
    end

    // Result latch and running maximum.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            res_q   <= '0;
            idx_q   <= '0;
            best_q  <= '0;
            best1_q <= '0;
        end else if (load) begin
            res_q <= result;
            idx_q <= '0;
        end else if (scan) begin
            if (take) begin
                best_q  <= cur;
                best1_q <= 4'(idx_q) + 4'd1;
            end
            idx_q <= last ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: accepts a feature vector, starts the FC
// datapath, streams weight ROM addresses, watches for a hung datapath and
// reports completion. Define FC_ARGMAX_EN to add the argmax class picker.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          layer_req,
    output logic                          layer_ack,
    input  logic                          abort,
    output logic                          fc_ready,
    input  logic                          fc_flag,
    input  logic                          fc_finish,
    input  logic [N_OUT-1:0][DATA_W-1:0]  fc_result,
    output logic [ADDR_W-1:0]             w_addr,
    output logic                          w_rd,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [3:0]                    class_idx,
    output logic                          class_valid
);

    localparam int TOTAL = N_IN * N_OUT;
    localparam int K_W   = $clog2(TOTAL + WD_SLACK + 1);
    // k values below this still have a weight left to fetch.
    localparam logic [K_W-1:0] K_ADDR_LAST = K_W'(TOTAL - 1);
    // Last RUN cycle allowed; without a finish here k would reach TOTAL+WD_SLACK.
    localparam logic [K_W-1:0] K_WD        = K_W'(TOTAL + WD_SLACK - 1);

`ifdef FC_ARGMAX_EN
    localparam fc_state_e AFTER_RUN = ARGMAX;
`else
    localparam fc_state_e AFTER_RUN = DONE;
`endif

    fc_state_e         state, state_nx;
    logic [K_W-1:0]    k_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              fc_take;
    logic              scan_last;

    // Next state and strobes; abort overrides everything at the end.
    always_comb begin
        state_nx    = state;
        layer_ack   = 1'b0;
        fc_ready    = 1'b0;
        w_rd        = 1'b0;
        w_addr      = addr_q;
        done        = 1'b0;
        class_valid = 1'b0;
        fc_take     = 1'b0;
        case (state)
            IDLE: begin
                if (layer_req) begin
                    // Mealy ack must still read 0 while reset is held.
                    layer_ack = n_reset;
                    state_nx  = ARM;
                end
            end
            ARM: begin
                fc_ready = 1'b1;
                w_rd     = 1'b1;
                w_addr   = '0;
                state_nx = RUN;
            end
            RUN: begin
                if (k_q < K_ADDR_LAST) begin
                    w_rd   = 1'b1;
                    w_addr = ADDR_W'(k_q + 1'b1);
                end
                if (k_q == '0 && !fc_flag) begin
                    state_nx = ERR;
                end else if (fc_finish) begin
                    fc_take  = 1'b1;
                    state_nx = AFTER_RUN;
                end else if (k_q == K_WD) begin
                    state_nx = ERR;
                end
            end
`ifdef FC_ARGMAX_EN
            ARGMAX: begin
                if (scan_last) state_nx = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
`ifdef FC_ARGMAX_EN
                class_valid = 1'b1;
`endif
                state_nx = IDLE;
            end
            ERR:     state_nx = ERR;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx    = IDLE;
            layer_ack   = 1'b0;
            fc_ready    = 1'b0;
            w_rd        = 1'b0;
            done        = 1'b0;
            class_valid = 1'b0;
            fc_take     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nx;
    end

    // RUN cycle counter (cleared on the way in from ARM) and held ROM address.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            k_q    <= '0;
            addr_q <= '0;
        end else begin
            addr_q <= w_addr;
            if (state == ARM)      k_q <= '0;
            else if (state == RUN) k_q <= k_q + 1'b1;
        end
    end

    // Sticky error: set on entry to ERR, cleared only by abort.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)              err_q <= 1'b0;
        else if (abort)            err_q <= 1'b0;
        else if (state_nx == ERR)  err_q <= 1'b1;
    end

    assign busy = (state != IDLE) && (state != ERR);
    assign err  = err_q;

`ifdef FC_ARGMAX_EN
    logic [3:0] scan_idx;
    logic [3:0] class_q;

    fc_argmax #(
        .N_OUT  (N_OUT),
        .DATA_W (DATA_W)
    ) u_argmax (
        .clk      (clk),
        .n_reset  (n_reset),
        .load     (fc_take),
        .result   (fc_result),
        .scan     (state == ARGMAX),
        .last     (scan_last),
        .best_idx (scan_idx)
    );

    // Winning class captured on the final scan cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                class_q <= '0;
        else if (scan_last && !abort) class_q <= scan_idx;
    end

    assign class_idx = class_q;
`else
    logic unused_no_argmax;
    assign scan_last        = 1'b0;
    assign class_idx        = '0;
    assign unused_no_argmax = ^{fc_result, fc_take, scan_last};
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: a table of full layer runs plus hand
// sequences for the stuck-datapath, watchdog, abort and async-reset cases.
module tb_fc_layer_seq;

    localparam int N_IN   = 30;
    localparam int N_OUT  = 10;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int TOTAL  = N_IN * N_OUT;

    logic                         clk = 1'b0;
    logic                         n_reset;
    logic                         layer_req, layer_ack, abort, fc_ready;
    logic                         fc_flag, fc_finish;
    logic [N_OUT-1:0][DATA_W-1:0] fc_result;
    logic [ADDR_W-1:0]            w_addr;
    logic                         w_rd, busy, done, err, class_valid;
    logic [3:0]                   class_idx;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int                           fin_k;   // RUN cycle carrying fc_finish
        logic [N_OUT-1:0][DATA_W-1:0] res;
        int                           exp_cls; // 1-based winner
    } vec_t;

    vec_t tbl[5];

    fc_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .n_reset(n_reset), .layer_req(layer_req), .layer_ack(layer_ack),
        .abort(abort), .fc_ready(fc_ready), .fc_flag(fc_flag), .fc_finish(fc_finish),
        .fc_result(fc_result), .w_addr(w_addr), .w_rd(w_rd), .busy(busy),
        .done(done), .err(err), .class_idx(class_idx), .class_valid(class_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Inputs change 2ns after the edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [N_OUT-1:0][DATA_W-1:0] mk(input int v[N_OUT]);
        logic [N_OUT-1:0][DATA_W-1:0] r;
        for (int i = 0; i < N_OUT; i++) r[i] = DATA_W'(v[i]);
        return r;
    endfunction

    task automatic run_layer(input vec_t v, input int id);
        int bad, first_k, exp_a, exp_rd, exp_cls, exp_cv;
        string tag;
        tag = $sformatf("row%0d", id);
`ifdef FC_ARGMAX_EN
        exp_cls = v.exp_cls;
        exp_cv  = 1;
`else
        exp_cls = 0;
        exp_cv  = 0;
`endif
        layer_req = 1'b1;
        settle();
        chk({tag, "_ack"}, int'(layer_ack), 1);
        step();
        fc_flag = 1'b1;
        settle();
        chk({tag, "_arm_ready"}, int'(fc_ready), 1);
        chk({tag, "_arm_addr"}, int'(w_addr) + 1000 * int'(w_rd), 1000);
        chk({tag, "_arm_ack"}, int'(layer_ack), 0);
        step();
        bad = 0;
        first_k = -1;
        for (int k = 0; k <= v.fin_k; k++) begin
            if (k == v.fin_k) begin
                fc_finish = 1'b1;
                fc_result = v.res;
            end
            settle();
            exp_rd = (k < TOTAL - 1) ? 1 : 0;
            exp_a  = (exp_rd == 1) ? k + 1 : TOTAL - 1;
            if (int'(w_rd) != exp_rd || int'(w_addr) != exp_a || fc_ready || done
                || !busy || err) begin
                if (bad == 0) first_k = k;
                bad++;
            end
            step();
        end
        chk({tag, "_run_seq_first_bad_k"}, first_k, -1);
        fc_finish = 1'b0;
        fc_flag   = 1'b0;
        fc_result = '1;
`ifdef FC_ARGMAX_EN
        bad = 0;
        for (int s = 0; s < N_OUT; s++) begin
            settle();
            if (done || class_valid || !busy) bad++;
            step();
        end
        chk({tag, "_scan_wait"}, bad, 0);
`endif
        settle();
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_class_valid"}, int'(class_valid), exp_cv);
        chk({tag, "_class_idx"}, int'(class_idx), exp_cls);
        chk({tag, "_done_ack"}, int'(layer_ack), 0);
        step();
        settle();
        chk({tag, "_reack"}, int'(layer_ack) + 10 * int'(busy), 1);
        layer_req = 1'b0;
        step();
    endtask

    initial begin
        int t[N_OUT];
        int bad;

        t = '{5, -3, 9, 9, 0, 0, 0, 0, 0, 0};
        tbl[0].fin_k = 300; tbl[0].res = mk(t); tbl[0].exp_cls = 3;
        t = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
        tbl[1].fin_k = 299; tbl[1].res = mk(t); tbl[1].exp_cls = 1;
        t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7};
        tbl[2].fin_k = 0;   tbl[2].res = mk(t); tbl[2].exp_cls = 10;
        t = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        tbl[3].fin_k = 303; tbl[3].res = mk(t); tbl[3].exp_cls = 1;
        t = '{100, 200, -300, 32767, 32767, -32768, 0, 0, 0, 1};
        tbl[4].fin_k = 150; tbl[4].res = mk(t); tbl[4].exp_cls = 4;

        n_reset = 1'b0; layer_req = 1'b0; abort = 1'b0;
        fc_flag = 1'b0; fc_finish = 1'b0; fc_result = '0;

        // Reset state.
        repeat (2) step();
        settle();
        chk("rst_strobes", int'({layer_ack, fc_ready, w_rd, done, class_valid}), 0);
        chk("rst_busy_err", int'({busy, err}), 0);
        chk("rst_addr", int'(w_addr), 0);
        chk("rst_class", int'(class_idx), 0);
        n_reset = 1'b1;
        step();

        // Stray fc_finish in IDLE is ignored.
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            fc_finish = 1'b1;
            settle();
            if (done || busy || class_valid || err) bad++;
            step();
        end
        fc_finish = 1'b0;
        settle();
        chk("idle_finish_ignored", bad + int'(busy), 0);
        step();

        for (int i = 0; i < 5; i++) run_layer(tbl[i], i);

        // Stuck datapath: flag never rises.
        layer_req = 1'b1;
        step();
        layer_req = 1'b0;
        settle();
        chk("stuck_ready", int'(fc_ready), 1);
        step();
        settle();
        chk("stuck_run0_err", int'(err) + 10 * int'(busy), 10);
        step();
        settle();
        chk("stuck_err", int'(err), 1);
        chk("stuck_busy", int'(busy), 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            layer_req = 1'b1;
            fc_finish = 1'b1;
            settle();
            if (!err || busy || layer_ack || done || w_rd || fc_ready) bad++;
            step();
        end
        fc_finish = 1'b0;
        chk("stuck_hold", bad, 0);
        abort = 1'b1;
        settle();
        chk("stuck_abort_ack", int'(layer_ack), 0);
        step();
        abort = 1'b0;
        layer_req = 1'b0;
        settle();
        chk("stuck_abort_clear", int'(err) + 10 * int'(busy), 0);
        step();

        // Watchdog: finish never arrives; err must be up when k reaches 304.
        layer_req = 1'b1;
        step();
        layer_req = 1'b0;
        fc_flag = 1'b1;
        step();
        bad = 0;
        for (int k = 0; k < TOTAL + 4; k++) begin
            settle();
            if (err || !busy) bad++;
            step();
        end
        chk("wd_quiet", bad, 0);
        settle();
        chk("wd_err", int'(err), 1);
        chk("wd_busy", int'(busy), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        fc_flag = 1'b0;
        settle();
        chk("wd_abort_clear", int'(err), 0);
        step();

        // Abort at k=100 together with fc_finish: abort wins.
        layer_req = 1'b1;
        step();
        layer_req = 1'b0;
        fc_flag = 1'b1;
        step();
        for (int k = 0; k < 100; k++) step();
        abort = 1'b1;
        fc_finish = 1'b1;
        fc_result = tbl[0].res;
        settle();
        chk("abort_wrd", int'(w_rd), 0);
        chk("abort_done", int'(done), 0);
        step();
        abort = 1'b0;
        fc_finish = 1'b0;
        fc_flag = 1'b0;
        settle();
        chk("abort_idle", int'({busy, err, w_rd, done}), 0);
        bad = 0;
        for (int i = 0; i < N_OUT + 2; i++) begin
            step();
            settle();
            if (done || class_valid || busy) bad++;
        end
        chk("abort_no_done", bad, 0);
        step();

        // Async reset mid-RUN.
        layer_req = 1'b1;
        step();
        fc_flag = 1'b1;
        step();
        for (int k = 0; k < 50; k++) step();
        n_reset = 1'b0;
        settle();
        chk("arst_strobes", int'({layer_ack, fc_ready, w_rd, done, class_valid}), 0);
        chk("arst_busy_err", int'({busy, err}), 0);
        chk("arst_addr", int'(w_addr), 0);
        layer_req = 1'b0;
        fc_flag = 1'b0;
        step();
        n_reset = 1'b1;
        step();
        run_layer(tbl[4], 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
